traffic_light_monitor: RTL and testbench
========================================

# traffic_light_monitor

Observer for the traffic light controller's lamp outputs. It decodes the red/yellow/green lines back into a phase and measures how many cycles each phase lasts. It flags illegal lamp patterns, illegal phase sequences and phase durations that do not match the programmed times. It sits beside the controller on the same clock, for on-chip self-check and for bench scoreboarding.

## Interface
Parameters:
- CNT_W, 9: duration counter width. Must be at least 9 so that time+1 for an 8-bit time fits.
- TOL, 1: allowed absolute deviation, in cycles, between measured and expected duration.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- maint_mode  in  1  controller maintenance mode; suspends checking.
- red_light, yellow_light, green_light  in  1 each  lamp lines from the controller.
- red_time, yellow_time, green_time  in  8 each  programmed phase times, same values the controller uses.
- clr_err  in  1  synchronous clear of err_count.
- phase  out  2  tracked phase: RED=00, YELLOW=01, GREEN=10.
- phase_valid  out  1  a legal phase is being tracked.
- phase_done  out  1  one-cycle pulse when a tracked phase ends.
- last_duration  out  CNT_W  cycle count of the phase that just ended.
- err_multi, err_dark, err_seq, err_time  out  1 each  one-cycle error pulses.
- err_count  out  8  saturating total of error pulses.

Every output resets to 0. phase resets to RED.

## Operation
- Lamp patterns are decoded as follows:
  - exactly one lamp on: a legal phase;
  - 000: dark;
  - two or more lamps on: multi.
- FSM states: IDLE, TRACK, MAINT. Reset enters IDLE.
- IDLE:
  - waits for a legal pattern;
  - on a legal pattern it loads phase, sets phase_valid, sets count=1, sets unchecked=1, and moves to TRACK.
- TRACK, same pattern as the tracked phase: count increments and saturates at 2^CNT_W-1.
- TRACK, legal new pattern:
  - phase_done pulses and last_duration is loaded with count;
  - the new phase is loaded and count=1;
  - legal transitions are R->G, G->Y and Y->R;
  - any other transition (for example R->Y) pulses err_seq and sets unchecked=1 for the new phase;
  - a legal transition clears unchecked, after the timing check below.
- TRACK, dark or multi:
  - err_dark or err_multi pulses;
  - phase_valid clears;
  - no phase_done;
  - the FSM goes to IDLE.
- Timing check, on phase_done when unchecked=0:
  - expected = programmed time of the ending phase + 1;
  - err_time pulses if |count - expected| > TOL;
  - the first phase after IDLE is partial and never checked.
- maint_mode=1, any state:
  - the FSM goes to MAINT;
  - no errors are raised;
  - phase_valid is 0 and counting stops;
  - on deassertion the FSM goes to IDLE and resynchronises.
- err_count:
  - increments by the number of error pulses in the cycle (at most 2: err_seq plus err_time);
  - saturates at 255;
  - clr_err clears it; when a clear and an error occur in the same cycle, the result is the new error count.

## Timing
- All outputs are registered. A lamp change sampled at edge k is reflected in phase, phase_done and the error pulses after edge k, i.e. with one cycle of latency.
- phase_done and the err_* pulses are exactly one cycle wide.
- last_duration holds its value until the next phase_done.
- Time compare arithmetic is unsigned and done at CNT_W+1 bits, so there is no wrap.
- Reset asserted mid-phase clears everything immediately; tracking restarts in IDLE.
- The programmed time inputs are sampled when the compare is made and may change freely between compares.

## Configuration
- TLM_TIMING_CHECK_EN defined: duration compare is present and err_time operates as described.
- TLM_TIMING_CHECK_EN undefined: compare logic is removed, err_time is tied to 0, and red_time, yellow_time and green_time are unused. Sequence and pattern checks and the duration measurement remain.

## Structure
- Package tlm_pkg holds:
  - phase_t enum (RED=2'b00, YELLOW=2'b01, GREEN=2'b10), matching the controller's encoding;
  - fsm state enum;
  - function next_legal(phase_t).
- Sub-module tlm_lamp_decode: combinational; three lamps in, phase/legal/dark/multi out. The top holds the FSM, counter, timing compare and error counter.

## Test plan
1. Reset: all outputs 0, phase=RED, phase_valid=0. Drive RED and release reset -> phase_valid=1 after the next edge.
2. red_time=3, green_time=5, yellow_time=2. Drive R for 4 cycles, G for 6, Y for 3, then R -> phase_done pulses with last_duration 4, 6 and 3; no errors, since the first R is unchecked.
3. Legal phase R followed directly by Y -> err_seq pulses once and err_count=1. The following Y->R completes with no err_time, because that Y is unchecked.
4. Drive red and green together for 2 cycles -> err_multi pulses once and phase_valid=0. Then drive G -> IDLE resync, phase=GREEN.
5. With TLM_TIMING_CHECK_EN, TOL=1, green_time=5, checked G:
   - G lasting 8 cycles -> err_time;
   - G lasting 7 cycles -> no error.
6. maint_mode=1 mid-green with lamps 110 for 10 cycles -> no errors and phase_valid=0. After deassertion, the first phase completes without err_time. clr_err together with an err_seq -> err_count=1.

Source files
------------

// File: rtl/tlm_pkg.sv
// Shared types for the traffic light monitor: lamp phase encoding (matches the
// controller), monitor FSM states and the legal phase successor.
package tlm_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } phase_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_TRACK = 2'b01,
    ST_MAINT = 2'b10
  } state_t;

  localparam int ERR_CNT_W = 8;

  function automatic phase_t next_legal(input phase_t p);
    case (p)
      RED:     return GREEN;
      GREEN:   return YELLOW;
      YELLOW:  return RED;
      default: return RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp/config inputs and check results of the traffic light monitor.
// master = controller/bench side, slave = monitor side.
interface traffic_light_monitor_if #(
  parameter int CNT_W = 9
);
  import tlm_pkg::*;

  logic             maint_mode;
  logic             red_light;
  logic             yellow_light;
  logic             green_light;
  logic [7:0]       red_time;
  logic [7:0]       yellow_time;
  logic [7:0]       green_time;
  logic             clr_err;

  phase_t           phase;
  logic             phase_valid;
  logic             phase_done;
  logic [CNT_W-1:0] last_duration;
  logic             err_multi;
  logic             err_dark;
  logic             err_seq;
  logic             err_time;
  logic [7:0]       err_count;

  modport master (
    output maint_mode, red_light, yellow_light, green_light,
    output red_time, yellow_time, green_time, clr_err,
    input  phase, phase_valid, phase_done, last_duration,
    input  err_multi, err_dark, err_seq, err_time, err_count
  );

  modport slave (
    input  maint_mode, red_light, yellow_light, green_light,
    input  red_time, yellow_time, green_time, clr_err,
    output phase, phase_valid, phase_done, last_duration,
    output err_multi, err_dark, err_seq, err_time, err_count
  );

endinterface

// File: rtl/tlm_lamp_decode.sv
// Combinational lamp decoder: one lamp on is a legal phase, none is dark,
// two or more is multi. phase is only meaningful when legal is set.
module tlm_lamp_decode
  import tlm_pkg::*;
(
  input  logic   red,
  input  logic   yellow,
  input  logic   green,
  output phase_t phase,
  output logic   legal,
  output logic   dark,
  output logic   multi
);

  logic [1:0] n_on;

  assign n_on  = {1'b0, red} + {1'b0, yellow} + {1'b0, green};
  assign legal = (n_on == 2'd1);
  assign dark  = (n_on == 2'd0);
  assign multi = (n_on >= 2'd2);

  always_comb begin
    phase = RED;
    if (green)  phase = GREEN;
    if (yellow) phase = YELLOW;
    if (red)    phase = RED;
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light lamp observer: phase tracking, duration measurement and error
// flagging. Define TLM_TIMING_CHECK_EN to include the phase-duration compare.
module traffic_light_monitor
  import tlm_pkg::*;
#(
  parameter int CNT_W = 9,
  parameter int TOL   = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  traffic_light_monitor_if.slave mon
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_add_err(input logic [ERR_CNT_W-1:0] v,
                                                       input logic [2:0] n);
    logic [ERR_CNT_W:0] s;
    s = {1'b0, v} + {{(ERR_CNT_W-2){1'b0}}, n};
    return s[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : s[ERR_CNT_W-1:0];
  endfunction

  phase_t dec_phase;
  logic   dec_legal, dec_dark, dec_multi;

  tlm_lamp_decode u_decode (
    .red    (mon.red_light),
    .yellow (mon.yellow_light),
    .green  (mon.green_light),
    .phase  (dec_phase),
    .legal  (dec_legal),
    .dark   (dec_dark),
    .multi  (dec_multi)
  );

  state_t               state_q, state_d;
  phase_t               phase_q, phase_d;
  logic                 valid_q, valid_d;
  logic                 unchk_q, unchk_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     last_q, last_d;
  logic                 multi_q, multi_d;
  logic                 dark_q, dark_d;
  logic                 seq_q, seq_d;
  logic                 time_q, time_d;
  logic [ERR_CNT_W-1:0] errc_q, errc_d;
  logic [2:0]           n_err;
  logic                 time_bad;

`ifdef TLM_TIMING_CHECK_EN
  logic [7:0]     prog_time;
  logic [CNT_W:0] exp_w, cnt_w, diff_w;

  // Compare one bit wider than the counter so time+1 and the difference never wrap.
  always_comb begin
    case (phase_q)
      RED:     prog_time = mon.red_time;
      YELLOW:  prog_time = mon.yellow_time;
      GREEN:   prog_time = mon.green_time;
      default: prog_time = mon.red_time;
    endcase
    exp_w    = {{(CNT_W-7){1'b0}}, prog_time} + 1'b1;
    cnt_w    = {1'b0, cnt_q};
    diff_w   = (cnt_w >= exp_w) ? (cnt_w - exp_w) : (exp_w - cnt_w);
    time_bad = (diff_w > (CNT_W+1)'(TOL));
  end
`else
  logic unused_times;
  assign unused_times = ^{mon.red_time, mon.yellow_time, mon.green_time};
  assign time_bad     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    valid_d = valid_q;
    unchk_d = unchk_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    done_d  = 1'b0;
    multi_d = 1'b0;
    dark_d  = 1'b0;
    seq_d   = 1'b0;
    time_d  = 1'b0;
    if (mon.maint_mode) begin
      state_d = ST_MAINT;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dec_legal) begin
            phase_d = dec_phase;
            valid_d = 1'b1;
            cnt_d   = CNT_W'(1);
            unchk_d = 1'b1;
            state_d = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (!dec_legal) begin
            dark_d  = dec_dark;
            multi_d = dec_multi;
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end else if (dec_phase == phase_q) begin
            cnt_d = sat_inc(cnt_q);
          end else begin
            // The ending phase is timed against its own programmed time before
            // unchecked is updated for the incoming phase.
            done_d  = 1'b1;
            last_d  = cnt_q;
            time_d  = !unchk_q && time_bad;
            seq_d   = (dec_phase != next_legal(phase_q));
            unchk_d = seq_d;
            phase_d = dec_phase;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_MAINT: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
    n_err  = {2'b00, multi_d} + {2'b00, dark_d} + {2'b00, seq_d} + {2'b00, time_d};
    errc_d = mon.clr_err ? {{(ERR_CNT_W-3){1'b0}}, n_err} : sat_add_err(errc_q, n_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= RED;
      valid_q <= 1'b0;
      unchk_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      last_q  <= '0;
      multi_q <= 1'b0;
      dark_q  <= 1'b0;
      seq_q   <= 1'b0;
      time_q  <= 1'b0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
      unchk_q <= unchk_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      multi_q <= multi_d;
      dark_q  <= dark_d;
      seq_q   <= seq_d;
      time_q  <= time_d;
      errc_q  <= errc_d;
    end
  end

  assign mon.phase         = phase_q;
  assign mon.phase_valid   = valid_q;
  assign mon.phase_done    = done_q;
  assign mon.last_duration = last_q;
  assign mon.err_multi     = multi_q;
  assign mon.err_dark      = dark_q;
  assign mon.err_seq       = seq_q;
  assign mon.err_time      = time_q;
  assign mon.err_count     = errc_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus randomized lamp
// segments, all checked every cycle against a phase/run-length reference model.
`timescale 1ns/1ps
module tb_traffic_light_monitor;
  import tlm_pkg::*;

  localparam int CNT_W = 9;
  localparam int TOL   = 1;
  localparam logic [2:0] L_R = 3'b100, L_Y = 3'b010, L_G = 3'b001;
`ifdef TLM_TIMING_CHECK_EN
  localparam bit TCHK = 1'b1;
`else
  localparam bit TCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  traffic_light_monitor_if #(.CNT_W(CNT_W)) mon ();

  traffic_light_monitor #(.CNT_W(CNT_W), .TOL(TOL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (mon)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode 0 = not tracking, 1 = tracking, 2 = maintenance.
  int m_mode, m_phase, m_run, m_last, m_cnt;
  bit m_valid, m_partial, m_done, m_multi, m_dark, m_seq, m_time;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_run = 0; m_last = 0; m_cnt = 0;
    m_valid = 0; m_partial = 0; m_done = 0;
    m_multi = 0; m_dark = 0; m_seq = 0; m_time = 0;
  endtask

  function automatic int prog_of(input int p);
    if (p == 0) return int'(mon.red_time);
    if (p == 1) return int'(mon.yellow_time);
    return int'(mon.green_time);
  endfunction

  function automatic int legal_next(input int p);
    return (p == 0) ? 2 : (p == 2) ? 1 : 0;
  endfunction

  function automatic int bad_next(input int p);
    return (p == 0) ? 1 : (p == 1) ? 2 : 0;
  endfunction

  function automatic logic [2:0] to_ryg(input int p);
    return (p == 0) ? L_R : (p == 1) ? L_Y : L_G;
  endfunction

  task automatic model_update(input logic [2:0] ryg, input bit mm, input bit clr);
    int ones, ph, dif, nerr;
    ones = $countones(ryg);
    ph = ryg[2] ? 0 : ryg[1] ? 1 : 2;
    m_done = 0; m_multi = 0; m_dark = 0; m_seq = 0; m_time = 0;
    if (mm) begin
      m_mode = 2; m_valid = 0;
    end else if (m_mode == 2) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (ones == 1) begin
        m_mode = 1; m_phase = ph; m_valid = 1; m_run = 1; m_partial = 1;
      end
    end else if (ones != 1) begin
      m_dark = (ones == 0); m_multi = (ones > 1); m_valid = 0; m_mode = 0;
    end else if (ph == m_phase) begin
      if (m_run < (1 << CNT_W) - 1) m_run++;
    end else begin
      m_done = 1; m_last = m_run;
      dif = m_run - (prog_of(m_phase) + 1);
      if (dif < 0) dif = -dif;
      m_time = TCHK && !m_partial && (dif > TOL);
      m_seq = (ph != legal_next(m_phase));
      m_partial = m_seq;
      m_phase = ph; m_run = 1;
    end
    nerr = int'(m_dark) + int'(m_multi) + int'(m_seq) + int'(m_time);
    if (clr) m_cnt = nerr;
    else m_cnt = (m_cnt + nerr > 255) ? 255 : m_cnt + nerr;
  endtask

  task automatic check_all();
    chk("phase", mon.phase, m_phase);
    chk("phase_valid", mon.phase_valid, m_valid);
    chk("phase_done", mon.phase_done, m_done);
    chk("last_duration", mon.last_duration, m_last);
    chk("err_multi", mon.err_multi, m_multi);
    chk("err_dark", mon.err_dark, m_dark);
    chk("err_seq", mon.err_seq, m_seq);
    chk("err_time", mon.err_time, m_time);
    chk("err_count", mon.err_count, m_cnt);
  endtask

  task automatic step(input logic [2:0] ryg, input bit mm, input bit clr);
    {mon.red_light, mon.yellow_light, mon.green_light} = ryg;
    mon.maint_mode = mm;
    mon.clr_err = clr;
    @(posedge clk);
    #1;
    model_update(ryg, mm, clr);
    check_all();
  endtask

  task automatic run(input logic [2:0] ryg, input int n);
    for (int i = 0; i < n; i++) step(ryg, 1'b0, 1'b0);
  endtask

  task automatic set_times(input int r, input int y, input int g);
    mon.red_time = 8'(r); mon.yellow_time = 8'(y); mon.green_time = 8'(g);
  endtask

  int cur, k, len, nxt;
  bit clr;
  logic [2:0] pat;

  initial begin
    mon.red_light = 0; mon.yellow_light = 0; mon.green_light = 0;
    mon.maint_mode = 0; mon.clr_err = 0;
    set_times(3, 2, 5);
    model_reset();

    // Reset state, then first legal phase.
    #1;
    check_all();
    @(posedge clk); #1;
    check_all();
    rst_n = 1'b1;
    step(L_R, 0, 0);
    chk("t1_valid", mon.phase_valid, 1);

    // Normal cycle R4 G6 Y3 R.
    run(L_R, 3);
    step(L_G, 0, 0);
    chk("t2_last_r", mon.last_duration, 4);
    run(L_G, 5);
    step(L_Y, 0, 0);
    chk("t2_last_g", mon.last_duration, 6);
    run(L_Y, 2);
    step(L_R, 0, 0);
    chk("t2_last_y", mon.last_duration, 3);
    chk("t2_errs", mon.err_count, 0);

    // Illegal R->Y, then an unchecked long Y.
    run(L_R, 2);
    step(L_Y, 0, 0);
    chk("t3_seq", mon.err_seq, 1);
    chk("t3_count", mon.err_count, 1);
    run(L_Y, 5);
    step(L_R, 0, 0);
    chk("t3_no_time", mon.err_time, 0);

    // Multi pattern and resync on green.
    run(L_R, 2);
    step(3'b101, 0, 0);
    chk("t4_multi", mon.err_multi, 1);
    chk("t4_valid", mon.phase_valid, 0);
    step(3'b101, 0, 0);
    step(L_G, 0, 0);
    chk("t4_phase", mon.phase, GREEN);

    // Duration checks on a checked green.
    run(L_Y, 3); run(L_R, 4); run(L_G, 8);
    step(L_Y, 0, 0);
    chk("t5_g8", mon.err_time, TCHK);
    run(L_Y, 2); run(L_R, 4); run(L_G, 7);
    step(L_Y, 0, 0);
    chk("t5_g7", mon.err_time, 0);

    // Maintenance mid-green with a multi pattern, then partial first phase.
    run(L_Y, 2); run(L_R, 4); run(L_G, 3);
    for (int i = 0; i < 10; i++) step(3'b110, 1, 0);
    chk("t6_maint_valid", mon.phase_valid, 0);
    run(L_G, 10);
    step(L_Y, 0, 0);
    chk("t6_no_time", mon.err_time, 0);
    run(L_Y, 2);
    step(L_G, 0, 1);
    chk("t6_clr_seq", mon.err_count, 1);

    // err_count saturation with back-to-back illegal transitions.
    for (int i = 0; i < 90; i++) begin
      step(L_R, 0, 0); step(L_Y, 0, 0); step(L_G, 0, 0);
    end
    chk("sat_255", mon.err_count, 255);

    // Asynchronous reset mid-phase.
    run(L_G, 2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cur = 2;
    step(L_G, 0, 0);

    // Randomized segments.
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 7) == 0)
        set_times($urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(1, 8));
      clr = ($urandom_range(0, 15) == 0);
      k = $urandom_range(0, 19);
      if (k == 0) begin
        run(3'b000, $urandom_range(1, 2));
      end else if (k == 1) begin
        pat = 3'($urandom_range(0, 3));
        pat = (pat == 0) ? 3'b110 : (pat == 1) ? 3'b101 : (pat == 2) ? 3'b011 : 3'b111;
        run(pat, $urandom_range(1, 2));
      end else if (k == 2) begin
        len = $urandom_range(1, 6);
        for (int i = 0; i < len; i++) begin
          pat = 3'($urandom_range(0, 7));
          step(pat, 1, 0);
        end
      end else begin
        nxt = (k == 3) ? bad_next(cur) : legal_next(cur);
        len = prog_of(nxt) + 1 + $urandom_range(0, 4) - 2;
        if (len < 1) len = 1;
        step(to_ryg(nxt), 0, clr);
        run(to_ryg(nxt), len - 1);
        cur = nxt;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
